// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arith_pkg
//  Description : Shared FSM state encoding for the serial arithmetic
//                controllers.
//  Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Single-bit full adder cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl
//  Description : Bit-serial WIDTH-bit add/subtract around one shared full
//                adder, LSB first, with valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int             CW   = $clog2(WIDTH);
    localparam int             ZW   = WIDTH - 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [ZW-1:0]     z_sh_q, z_sh_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  z_q, z_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic              fa_sum;
    logic              fa_cout;

    full_adder u_fa (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            z_sh_q  <= '0;
            carry_q <= 1'b0;
            z_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            z_sh_q  <= z_sh_d;
            carry_q <= carry_d;
            z_q     <= z_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        z_sh_d  = z_sh_q;
        carry_d = carry_q;
        z_d     = z_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1, so borrow-in becomes an inverted carry-in.
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    count_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                z_sh_d  = ZW'({fa_sum, z_sh_q} >> 1);
                carry_d = fa_cout;
                if (count_q == LAST) begin
                    // carry_q here is the carry into the MSB.
                    z_d     = {fa_sum, z_sh_q};
                    cout_d  = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;
                    state_d = S_DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign z         = z_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder_ctrl
//  Description : Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             cout;
    logic             ovf;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands in IDLE and step through the accept edge.
    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts);
        check("start_in_ready", 32'(in_ready), 32'd1);
        a = ta; b = tb; cin = tc; sub = ts;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("accept_busy", 32'(busy), 32'd1);
    endtask

    // Count edges after accept until out_valid, then compare the result.
    task automatic wait_result(input string tag, input logic [7:0] ez, input logic ec, input logic eo);
        int n;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            tick();
            n++;
        end
        check({tag, "_lat"},  32'(n),    32'd8);
        check({tag, "_z"},    32'(z),    32'(ez));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"},  32'(ovf),  32'(eo));
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("rel_out_valid", 32'(out_valid), 32'd0);
        check("rel_in_ready",  32'(in_ready),  32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_z",         32'(z),         32'h00);
        check("rst_cout",      32'(cout),      32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);

        // Signed overflow add
        start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        wait_result("add1", 8'h96, 1'b0, 1'b1);
        release_result();

        // Carry out with carry-in; result must persist in IDLE
        start_op(8'hFF, 8'h01, 1'b1, 1'b0);
        wait_result("add2", 8'h01, 1'b1, 1'b0);
        release_result();
        tick();
        check("idle_hold_z",    32'(z),    32'h01);
        check("idle_hold_cout", 32'(cout), 32'd1);

        // Subtract with borrow
        start_op(8'h10, 8'h20, 1'b0, 1'b1);
        wait_result("sub1", 8'hF0, 1'b0, 1'b0);
        release_result();

        // Subtract with signed overflow
        start_op(8'h80, 8'h01, 1'b0, 1'b1);
        wait_result("sub2", 8'h7F, 1'b1, 1'b1);
        release_result();

        // Subtract with borrow-in
        start_op(8'h05, 8'h02, 1'b1, 1'b1);
        wait_result("sub3", 8'h02, 1'b1, 1'b0);

        // Back-pressure: result held, new operands ignored
        for (int i = 0; i < 5; i++) begin
            a = 8'(8'h11 * (i + 1)); b = 8'h33; in_valid = 1'b1;
            tick();
            check("bp_z",         32'(z),         32'h02);
            check("bp_cout",      32'(cout),      32'd1);
            check("bp_ovf",       32'(ovf),       32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        // in_valid together with out_ready in DONE completes only the output
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_rel_out_valid", 32'(out_valid), 32'd0);
        check("bp_rel_in_ready",  32'(in_ready),  32'd1);
        check("bp_rel_busy",      32'(busy),      32'd0);

        // Reset mid-RUN aborts the operation
        start_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_z",         32'(z),         32'h00);
        tick();
        check("abort_no_valid",  32'(out_valid), 32'd0);

        start_op(8'h01, 8'h01, 1'b0, 1'b0);
        wait_result("post", 8'h02, 1'b0, 1'b0);
        release_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
